// File: rtl/sp_sweep_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sp_sweep_tracker
// Purpose  : Two-axis maximum-power sweep controller for a solar panel.
//            It sweeps the horizontal servo index, then the vertical index.
//            After each step it waits SETTLE ticks and takes the next valid
//            voltage sample, and it remembers the strict maximum and where it
//            was found. It then parks on the best position, holds there for
//            HOLD_TICKS ticks and starts the sweep again. A manual jog mode
//            moves the servos from the push buttons.
// Ports    : clk / rst_n            clock, asynchronous active-low reset
//            tick_i                 one-cycle step enable; all timing is in ticks
//            start_i                starts a sweep from IDLE
//            manual_i               1 = manual jog mode (highest priority)
//            btn_l/r/u/d_i          jog buttons (already debounced)
//            v_in_i / v_valid_i     panel voltage sample and its strobe
//            pos_h_o / pos_v_o      servo position indices
//            max_v_o                best sample of the current or last sweep
//            busy_o                 high from H_SWEEP to V_RETURN
//            stat_o                 state code
// Revision : 1.0  initial release
// ============================================================================
module sp_sweep_tracker #(
    parameter int V_W        = 12,
    parameter int POS_W      = 8,
    parameter int H_STEPS    = 180,
    parameter int V_STEPS    = 90,
    parameter int SETTLE     = 100,
    parameter int HOLD_TICKS = 10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_i,
    input  logic             start_i,
    input  logic             manual_i,
    input  logic             btn_l_i,
    input  logic             btn_r_i,
    input  logic             btn_u_i,
    input  logic             btn_d_i,
    input  logic [V_W-1:0]   v_in_i,
    input  logic             v_valid_i,
    output logic [POS_W-1:0] pos_h_o,
    output logic [POS_W-1:0] pos_v_o,
    output logic [V_W-1:0]   max_v_o,
    output logic             busy_o,
    output logic [2:0]       stat_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] C_ST_IDLE     = 3'd0;
    localparam logic [2:0] C_ST_H_SWEEP  = 3'd1;
    localparam logic [2:0] C_ST_H_RETURN = 3'd2;
    localparam logic [2:0] C_ST_V_SWEEP  = 3'd3;
    localparam logic [2:0] C_ST_V_RETURN = 3'd4;
    localparam logic [2:0] C_ST_HOLD     = 3'd5;
    localparam logic [2:0] C_ST_MANUAL   = 3'd6;

    localparam int C_SET_W  = $clog2(SETTLE + 1);
    localparam int C_HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [POS_W-1:0]    C_H_LAST    = POS_W'(H_STEPS - 1);
    localparam logic [POS_W-1:0]    C_V_LAST    = POS_W'(V_STEPS - 1);
    localparam logic [POS_W-1:0]    C_H_MID     = POS_W'(H_STEPS / 2);
    localparam logic [POS_W-1:0]    C_V_MID     = POS_W'(V_STEPS / 2);
    localparam logic [POS_W-1:0]    C_POS_ONE   = POS_W'(1);
    localparam logic [C_SET_W-1:0]  C_SETTLE    = C_SET_W'(SETTLE);
    localparam logic [C_SET_W-1:0]  C_SET_ONE   = C_SET_W'(1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_TICKS - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_ONE  = C_HOLD_W'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]          state_q,  state_d;
    logic [POS_W-1:0]    pos_h_q,  pos_h_d;
    logic [POS_W-1:0]    pos_v_q,  pos_v_d;
    logic [POS_W-1:0]    best_h_q, best_h_d;
    logic [POS_W-1:0]    best_v_q, best_v_d;
    logic [V_W-1:0]      max_v_q,  max_v_d;
    logic [C_SET_W-1:0]  settle_q, settle_d;
    logic [C_HOLD_W-1:0] hold_q,   hold_d;
    logic                busy_q,   busy_d;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    logic w_settled;
    logic w_sample;
    logic w_higher;
    logic w_h_last;
    logic w_v_last;
    logic w_hold_done;
    logic w_enter_h;

    assign w_settled   = (settle_q == C_SETTLE);
    // The first valid strobe after the settle window is the sample. Strobes
    // that arrive while the servo is still settling are ignored.
    assign w_sample    = w_settled && v_valid_i;
    // Strict compare: on a tie the earlier position is kept.
    assign w_higher    = (v_in_i > max_v_q);
    assign w_h_last    = (pos_h_q == C_H_LAST);
    assign w_v_last    = (pos_v_q == C_V_LAST);
    assign w_hold_done = tick_i && (hold_q == C_HOLD_LAST);
    // A new horizontal sweep starts from IDLE on start, or from HOLD when the
    // hold period ends. Manual mode has priority over both.
    assign w_enter_h   = !manual_i &&
                         (((state_q == C_ST_IDLE) && start_i) ||
                          ((state_q == C_ST_HOLD) && w_hold_done));

    // ------------------------------------------------------------------------
    // Process 1: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= C_ST_IDLE;
            pos_h_q  <= C_H_MID;
            pos_v_q  <= C_V_MID;
            best_h_q <= '0;
            best_v_q <= '0;
            max_v_q  <= '0;
            settle_q <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_h_q  <= pos_h_d;
            pos_v_q  <= pos_v_d;
            best_h_q <= best_h_d;
            best_v_q <= best_v_d;
            max_v_q  <= max_v_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (manual_i) begin
            state_d = C_ST_MANUAL;
        end else begin
            case (state_q)
                C_ST_IDLE:     if (start_i) state_d = C_ST_H_SWEEP;
                C_ST_H_SWEEP:  if (w_sample && w_h_last) state_d = C_ST_H_RETURN;
                C_ST_H_RETURN: state_d = C_ST_V_SWEEP;
                C_ST_V_SWEEP:  if (w_sample && w_v_last) state_d = C_ST_V_RETURN;
                C_ST_V_RETURN: state_d = C_ST_HOLD;
                C_ST_HOLD:     if (w_hold_done) state_d = C_ST_H_SWEEP;
                C_ST_MANUAL:   state_d = C_ST_IDLE;
                default:       state_d = C_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Process 3: datapath and registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        pos_h_d  = pos_h_q;
        pos_v_d  = pos_v_q;
        best_h_d = best_h_q;
        best_v_d = best_v_q;
        max_v_d  = max_v_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        busy_d   = (state_d >= C_ST_H_SWEEP) && (state_d <= C_ST_V_RETURN);

        if (manual_i) begin
            // Jog only once the controller is already in manual mode. On the
            // cycle that manual mode is entered, everything holds.
            if ((state_q == C_ST_MANUAL) && tick_i) begin
                if (btn_l_i && !btn_r_i && (pos_h_q != '0)) begin
                    pos_h_d = pos_h_q - C_POS_ONE;
                end else if (btn_r_i && !btn_l_i && (pos_h_q != C_H_LAST)) begin
                    pos_h_d = pos_h_q + C_POS_ONE;
                end
                if (btn_d_i && !btn_u_i && (pos_v_q != '0)) begin
                    pos_v_d = pos_v_q - C_POS_ONE;
                end else if (btn_u_i && !btn_d_i && (pos_v_q != C_V_LAST)) begin
                    pos_v_d = pos_v_q + C_POS_ONE;
                end
            end
        end else begin
            case (state_q)
                C_ST_H_SWEEP: begin
                    if (!w_settled) begin
                        if (tick_i) settle_d = settle_q + C_SET_ONE;
                    end else if (v_valid_i) begin
                        if (w_higher) begin
                            max_v_d  = v_in_i;
                            best_h_d = pos_h_q;
                        end
                        if (!w_h_last) pos_h_d = pos_h_q + C_POS_ONE;
                        settle_d = '0;
                    end
                end
                C_ST_H_RETURN: begin
                    pos_h_d  = best_h_q;
                    // The current vertical position is the default best, so
                    // the V axis moves only on a strictly higher sample.
                    best_v_d = pos_v_q;
                    pos_v_d  = '0;
                    settle_d = '0;
                end
                C_ST_V_SWEEP: begin
                    if (!w_settled) begin
                        if (tick_i) settle_d = settle_q + C_SET_ONE;
                    end else if (v_valid_i) begin
                        if (w_higher) begin
                            max_v_d  = v_in_i;
                            best_v_d = pos_v_q;
                        end
                        if (!w_v_last) pos_v_d = pos_v_q + C_POS_ONE;
                        settle_d = '0;
                    end
                end
                C_ST_V_RETURN: begin
                    pos_v_d = best_v_q;
                    hold_d  = '0;
                end
                C_ST_HOLD: begin
                    if (tick_i && !w_hold_done) hold_d = hold_q + C_HOLD_ONE;
                end
                default: ;
            endcase

            if (w_enter_h) begin
                pos_h_d  = '0;
                best_h_d = '0;
                max_v_d  = '0;
                settle_d = '0;
            end
        end
    end

    assign pos_h_o = pos_h_q;
    assign pos_v_o = pos_v_q;
    assign max_v_o = max_v_q;
    assign busy_o  = busy_q;
    assign stat_o  = state_q;

endmodule
`default_nettype wire
